// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the cache arbiter slice.
// Tie-break policy is selected in cache_arbiter_grant by ARB_ROUND_ROBIN_EN.
package cache_arb_types;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LINE_WIDTH_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_e;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } owner_e;

  // The cache that did not just win, used to advance the round-robin pointer.
  function automatic owner_e other_owner(input owner_e owner);
    return (owner == OWNER_I) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the icache, dcache and adaptor physical-memory signals.
// slave: the arbiter's view. master: the caches plus adaptor around it.
interface cache_arbiter_if
  import cache_arb_types::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
);

  logic                  icache_pmem_read;
  logic [ADDR_WIDTH-1:0] icache_pmem_address;
  logic [LINE_WIDTH-1:0] icache_pmem_rdata;
  logic                  icache_pmem_resp;

  logic                  dcache_pmem_read;
  logic                  dcache_pmem_write;
  logic [ADDR_WIDTH-1:0] dcache_pmem_address;
  logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
  logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
  logic                  dcache_pmem_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_arbiter_grant.sv
// Combinational winner select between the icache and dcache.
// ARB_ROUND_ROBIN_EN defined: ties go to the cache named by rr_ptr.
// ARB_ROUND_ROBIN_EN undefined: ties always go to the dcache.
module cache_arbiter_grant
  import cache_arb_types::*;
(
  input  logic   pend_i,
  input  logic   pend_d,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e rr_ptr,
`endif
  output logic   grant,
  output owner_e winner
);

  // Pick a winner whenever at least one cache is asking.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
    grant  = pend_i | pend_d;
    winner = OWNER_D;
    if (pend_i && pend_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = rr_ptr;
`else
      // dcache misses and writebacks stall the pipeline longer, so they win ties.
      winner = OWNER_D;
`endif
    end else if (pend_i) begin
      winner = OWNER_I;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Merges icache and dcache line requests onto one adaptor port.
// One request is latched and held until mem_resp; the resp pulse goes only
// to the granted cache. ARB_ROUND_ROBIN_EN adds a round-robin tie pointer.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  state_e                state;
  state_e                state_next;
  logic                  pend_i;
  logic                  pend_d;
  logic                  grant;
  owner_e                winner;
  logic                  take;

  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_wdata;

  assign pend_i = bus.icache_pmem_read;
  assign pend_d = bus.dcache_pmem_read | bus.dcache_pmem_write;
  assign take   = (state == IDLE) && grant;

  // Read data is broadcast; each cache qualifies it with its own resp.
  assign bus.icache_pmem_rdata = bus.mem_rdata;
  assign bus.dcache_pmem_rdata = bus.mem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e rr_ptr;

  // Round-robin pointer: after each grant the other cache owns the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= OWNER_I;
    end else if (take) begin
      rr_ptr <= other_owner(winner);
    end
  end
`endif

  cache_arbiter_grant u_grant (
    .pend_i (pend_i),
    .pend_d (pend_d),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr (rr_ptr),
`endif
    .grant  (grant),
    .winner (winner)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on mem_resp.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant) state_next = (winner == OWNER_I) ? SERVE_I : SERVE_D;
      SERVE_I: if (bus.mem_resp) state_next = IDLE;
      SERVE_D: if (bus.mem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request registers: capture the winner's op, address and line at the grant edge.
  always_ff @(posedge clk) begin
    // NOTE: these wide datapath registers are reset only because mem_address/mem_wdata must read 0 after reset.
    if (rst) begin
      req_read  <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (take) begin
      if (winner == OWNER_I) begin
        req_read  <= 1'b1;
        req_write <= 1'b0;
        req_addr  <= bus.icache_pmem_address;
        req_wdata <= '0;
      end else begin
        // A simultaneous read+write from the dcache is treated as a write.
        req_read  <= bus.dcache_pmem_read & ~bus.dcache_pmem_write;
        req_write <= bus.dcache_pmem_write;
        req_addr  <= bus.dcache_pmem_address;
        req_wdata <= bus.dcache_pmem_wdata;
      end
    end
  end

  // Outputs: hold the latched request while serving; route mem_resp to the owner.
  always_comb begin
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.mem_address      = req_addr;
    bus.mem_wdata        = req_wdata;
    bus.icache_pmem_resp = 1'b0;
    bus.dcache_pmem_resp = 1'b0;
    unique case (state)
      SERVE_I: begin
        bus.mem_read         = req_read;
        bus.mem_write        = req_write;
        bus.icache_pmem_resp = bus.mem_resp & ~rst;
      end
      SERVE_D: begin
        bus.mem_read         = req_read;
        bus.mem_write        = req_write;
        bus.dcache_pmem_resp = bus.mem_resp & ~rst;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter; the bench plays both caches and the adaptor.
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_cache_arbiter;

  logic clk;
  logic rst;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_d, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wdata);
    txn_t t;
    t.is_d  = is_d;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wdata;
    sb.push_back(t);
  endtask

  task automatic drive_i(input logic [31:0] addr);
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = addr;
  endtask

  task automatic drive_d(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wdata);
    bus.dcache_pmem_read    = rd;
    bus.dcache_pmem_write   = wr;
    bus.dcache_pmem_address = addr;
    bus.dcache_pmem_wdata   = wdata;
  endtask

  task automatic clear_owner(input bit is_d);
    if (is_d) begin
      bus.dcache_pmem_read  = 1'b0;
      bus.dcache_pmem_write = 1'b0;
    end else begin
      bus.icache_pmem_read = 1'b0;
    end
  endtask

  task automatic clear_all();
    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;
    bus.mem_rdata           = '0;
    bus.mem_resp            = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Adaptor model: waits for the next request, pops the expected one and
  // completes it after `latency` active cycles.
  task automatic serve(input int exp_wait, input int latency, input logic [255:0] rdata,
                       input bit perturb, input bit drop_mid);
    int   waited;
    txn_t e;
    waited = 0;
    while (!(bus.mem_read || bus.mem_write) && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: request seen with no expected transaction queued");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (!(bus.mem_read || bus.mem_write)) begin
      failures++;
      $display("FAIL grant_timeout: no mem request within %0d cycles, expected addr %h",
               waited, e.addr);
      return;
    end
    checks++;
    if (waited != exp_wait) begin
      failures++;
      $display("FAIL grant_latency: waited %0d cycles, expected %0d", waited, exp_wait);
    end
    checks++;
    if (bus.mem_read !== !e.wr || bus.mem_write !== e.wr) begin
      failures++;
      $display("FAIL op: mem_read=%b mem_write=%b, expected %b/%b",
               bus.mem_read, bus.mem_write, !e.wr, e.wr);
    end
    checks++;
    if (bus.mem_address !== e.addr) begin
      failures++;
      $display("FAIL addr: mem_address=%h, expected %h", bus.mem_address, e.addr);
    end
    checks++;
    if (bus.mem_wdata !== e.wdata) begin
      failures++;
      $display("FAIL wdata: mem_wdata=%h, expected %h", bus.mem_wdata, e.wdata);
    end
    for (int c = 2; c < latency + 1; c++) begin
      if (c == latency) break;
      tick();
      if (perturb) begin
        bus.dcache_pmem_address = $urandom;
        bus.dcache_pmem_wdata   = {8{$urandom}};
      end
      if (drop_mid) clear_owner(e.is_d);
      #1;
      checks++;
      if (bus.mem_read !== !e.wr || bus.mem_write !== e.wr ||
          bus.mem_address !== e.addr || bus.mem_wdata !== e.wdata ||
          bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0) begin
        failures++;
        $display("FAIL hold: cycle %0d rd=%b wr=%b addr=%h iresp=%b dresp=%b, expected rd=%b wr=%b addr=%h no resp",
                 c, bus.mem_read, bus.mem_write, bus.mem_address,
                 bus.icache_pmem_resp, bus.dcache_pmem_resp, !e.wr, e.wr, e.addr);
      end
    end
    if (latency > 1) tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    checks++;
    if (bus.icache_pmem_resp !== !e.is_d || bus.dcache_pmem_resp !== e.is_d) begin
      failures++;
      $display("FAIL resp: icache_resp=%b dcache_resp=%b, expected %b/%b",
               bus.icache_pmem_resp, bus.dcache_pmem_resp, !e.is_d, e.is_d);
    end
    checks++;
    if (bus.icache_pmem_rdata !== rdata || bus.dcache_pmem_rdata !== rdata) begin
      failures++;
      $display("FAIL rdata: icache=%h dcache=%h, expected %h",
               bus.icache_pmem_rdata, bus.dcache_pmem_rdata, rdata);
    end
    tick();
    bus.mem_resp = 1'b0;
    clear_owner(e.is_d);
    #1;
    checks++;
    if (bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0 ||
        bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("FAIL idle_gap: iresp=%b dresp=%b rd=%b wr=%b, expected all 0",
               bus.icache_pmem_resp, bus.dcache_pmem_resp, bus.mem_read, bus.mem_write);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_all();
    tick();
    tick();
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_address !== 32'h0 ||
        bus.mem_wdata !== 256'h0 || bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL reset: rd=%b wr=%b addr=%h iresp=%b dresp=%b, expected all 0",
               bus.mem_read, bus.mem_write, bus.mem_address,
               bus.icache_pmem_resp, bus.dcache_pmem_resp);
    end
    rst = 1'b0;
  endtask

  task automatic test_icache_read();
    drive_i(32'h0000_0040);
    push(1'b0, 1'b0, 32'h0000_0040, '0);
    serve(1, 4, {32{8'hA5}}, 1'b0, 1'b0);
  endtask

  task automatic test_dcache_writeback();
    logic [255:0] w;
    w = {8{32'h1234_5678}};
    drive_d(1'b0, 1'b1, 32'h0000_1000, w);
    push(1'b1, 1'b1, 32'h0000_1000, w);
    serve(1, 4, {8{32'hDEAD_BEEF}}, 1'b1, 1'b0);
  endtask

  task automatic test_boundaries();
    // Minimum latency: mem_resp in the very first serve cycle.
    drive_d(1'b1, 1'b0, 32'h0000_0C00, {8{32'h0BAD_F00D}});
    push(1'b1, 1'b0, 32'h0000_0C00, {8{32'h0BAD_F00D}});
    serve(1, 1, {8{32'h5A5A_0001}}, 1'b0, 1'b0);
    // Request dropped mid-service is still completed.
    drive_i(32'h0000_0140);
    push(1'b0, 1'b0, 32'h0000_0140, '0);
    serve(1, 3, {8{32'h0F0F_0F0F}}, 1'b0, 1'b1);
    // Read and write together from the dcache becomes a write.
    drive_d(1'b1, 1'b1, 32'h0000_1800, {8{32'hCAFE_0001}});
    push(1'b1, 1'b1, 32'h0000_1800, {8{32'hCAFE_0001}});
    serve(1, 2, {8{32'h1111_2222}}, 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    do_reset();
    drive_i(32'h0000_0080);
    drive_d(1'b1, 1'b0, 32'h0000_2000, '0);
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b0, 32'h0000_0080, '0);
    push(1'b1, 1'b0, 32'h0000_2000, '0);
    serve(1, 2, {8{32'hA000_0001}}, 1'b0, 1'b0);
    // Re-raise icache so the dcache meets it in a second tie.
    drive_i(32'h0000_00C0);
    push(1'b0, 1'b0, 32'h0000_00C0, '0);
    serve(1, 2, {8{32'hA000_0002}}, 1'b0, 1'b0);
    serve(1, 2, {8{32'hA000_0003}}, 1'b0, 1'b0);
`else
    push(1'b1, 1'b0, 32'h0000_2000, '0);
    push(1'b0, 1'b0, 32'h0000_0080, '0);
    serve(1, 2, {8{32'hA000_0001}}, 1'b0, 1'b0);
    serve(1, 2, {8{32'hA000_0002}}, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_rr_fairness();
    drive_d(1'b1, 1'b0, 32'h0000_4000, '0);
    push(1'b1, 1'b0, 32'h0000_4000, '0);
    tick();
    drive_i(32'h0000_0500);
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b0, 32'h0000_0500, '0);
`endif
    serve(0, 3, {8{32'hB000_0000}}, 1'b0, 1'b0);
    drive_d(1'b1, 1'b0, 32'h0000_4040, '0);
    push(1'b1, 1'b0, 32'h0000_4040, '0);
`ifndef ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b0, 32'h0000_0500, '0);
`endif
    serve(1, 2, {8{32'hB000_0001}}, 1'b0, 1'b0);
    serve(1, 2, {8{32'hB000_0002}}, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive_d(1'b1, 1'b0, 32'h0000_3000, '0);
    tick();
    checks++;
    if (bus.mem_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_start: mem_read=%b, expected 1", bus.mem_read);
    end
    tick();
    rst           = 1'b1;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{32'hEEEE_EEEE}};
    #1;
    checks++;
    if (bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_resp: iresp=%b dresp=%b, expected 0/0",
               bus.icache_pmem_resp, bus.dcache_pmem_resp);
    end
    tick();
    bus.mem_resp = 1'b0;
    clear_owner(1'b1);
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_address !== 32'h0 ||
        bus.dcache_pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle: rd=%b wr=%b addr=%h dresp=%b, expected 0/0/0/0",
               bus.mem_read, bus.mem_write, bus.mem_address, bus.dcache_pmem_resp);
    end
    rst = 1'b0;
    drive_i(32'h0000_0600);
    push(1'b0, 1'b0, 32'h0000_0600, '0);
    serve(1, 2, {8{32'hC000_0001}}, 1'b0, 1'b0);
  endtask

  task automatic test_spurious_resp();
    logic [255:0] r;
    r = {8{32'h7777_1234}};
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = r;
    #1;
    checks++;
    if (bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL spurious_resp: iresp=%b dresp=%b, expected 0/0",
               bus.icache_pmem_resp, bus.dcache_pmem_resp);
    end
    checks++;
    if (bus.icache_pmem_rdata !== r || bus.dcache_pmem_rdata !== r) begin
      failures++;
      $display("FAIL broadcast: icache=%h dcache=%h, expected %h",
               bus.icache_pmem_rdata, bus.dcache_pmem_rdata, r);
    end
    tick();
    bus.mem_resp = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("FAIL spurious_state: rd=%b wr=%b, expected 0/0", bus.mem_read, bus.mem_write);
    end
    drive_i(32'h0000_0700);
    push(1'b0, 1'b0, 32'h0000_0700, '0);
    serve(1, 2, {8{32'hD000_0001}}, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_dcache_writeback();
    test_boundaries();
    test_tie();
    test_rr_fairness();
    test_reset_mid();
    test_spurious_resp();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d expected transactions never served, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
